// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } fetch_state_e;

  localparam logic [3:0]  HALT_OP_DEFAULT = 4'hF;
  localparam int unsigned PC_STEP_DEFAULT = 2;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
  } inst_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter with enable that sticks at 0xFFFF.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'h0000;
    end else if (en && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, captures instructions, handles redirect/halt/fault.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned PC_STEP   = PC_STEP_DEFAULT,
  parameter int unsigned MEM_BYTES = 52,
  parameter logic [3:0]  HALT_OP   = HALT_OP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] pc_o,
  input  logic [3:0]  im_one,
  input  logic [3:0]  im_two,
  input  logic [3:0]  im_three,
  input  logic [3:0]  im_four,
  output logic [15:0] inst_o,
  output logic [15:0] inst_pc_o,
  output logic        inst_valid,
  input  logic        dec_ready,
  input  logic        redir_valid,
  input  logic [15:0] redir_pc,
`ifdef FETCH_CTRL_PERF_EN
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_stall_cnt,
`endif
  output logic        halted,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  inst_q, inst_d;
  logic [15:0]  inst_pc_q, inst_pc_d;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  logic         fault_q, fault_d;
  logic         slot_free, pc_oob, capture;
  inst_t        im_word;

  assign im_word   = {im_one, im_two, im_three, im_four};
  assign slot_free = !valid_q || dec_ready;
  // Widened so the bound check cannot wrap.
  assign pc_oob    = ({16'h0000, pc_q} + 32'd1) >= MEM_BYTES;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    fault_d   = fault_q;
    capture   = 1'b0;

    if (state_q != IDLE && redir_valid) begin
      pc_d     = {redir_pc[15:1], 1'b0};
      valid_d  = 1'b0;
      halted_d = 1'b0;
      fault_d  = 1'b0;
      state_d  = FETCH;
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (slot_free) begin
            if (pc_oob) begin
              fault_d = 1'b1;
              state_d = HALT;
              if (dec_ready) valid_d = 1'b0;
            end else begin
              capture   = 1'b1;
              inst_d    = im_word;
              inst_pc_d = pc_q;
              valid_d   = 1'b1;
              pc_d      = pc_q + 16'(PC_STEP);
              if (im_word.op == HALT_OP) begin
                halted_d = 1'b1;
                state_d  = HALT;
              end
            end
          end
        end
        HALT: begin
          if (valid_q && dec_ready) valid_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= 16'h0000;
      inst_pc_q <= 16'h0000;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

  assign pc_o       = pc_q;
  assign inst_o     = inst_q;
  assign inst_pc_o  = inst_pc_q;
  assign inst_valid = valid_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

`ifdef FETCH_CTRL_PERF_EN
  sat_counter16 u_fetch_cnt (
    .clk (clk),
    .rst (rst),
    .en  (capture),
    .cnt (perf_fetch_cnt)
  );

  sat_counter16 u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (valid_q && !dec_ready),
    .cnt (perf_stall_cnt)
  );
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule
